mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the byte-serial memory port driven by the CPU's memory controller. It implements the RAM array and the memory-mapped I/O window. It answers single-byte reads with a one-cycle registered latency and commits single-byte writes at the issuing edge. It also buffers console output and input in small FIFOs and exposes a back-pressure flag (`io_full`) and a simulation halt flag.

## Interface
- `ADDR_WID`, 17, RAM index width; RAM depth = 2^ADDR_WID bytes
- `FIFO_LOG`, 3, log2 of TX/RX FIFO depth (depth 8)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `mem_addr`  in  32  byte address from memory controller
- `mem_rw`  in  1  1 = write, 0 = read
- `mem_wdata`  in  8  write byte
- `mem_rdata`  out  8  read byte, registered
- `io_full`  out  1  TX FIFO near-full; controller must not issue I/O writes while high
- `tx_valid`  out  1  TX FIFO non-empty
- `tx_data`  out  8  TX FIFO head byte
- `tx_ready`  in  1  sink accepts head byte this cycle
- `rx_valid`  in  1  source offers an input byte
- `rx_data`  in  8  input byte
- `rx_ready`  out  1  RX FIFO has room
- `halt`  out  1  sticky; program requested stop

## Operation
- Decode: I/O window when `mem_addr[17:16]==2'b11`; otherwise RAM at index `mem_addr[ADDR_WID-1:0]`. Upper address bits are ignored, so RAM addresses wrap around.
- RAM read: array byte at the index is registered to `mem_rdata`.
- RAM write: array byte is updated. `mem_rdata` takes 0.
- I/O addresses, by `mem_addr[2:0]`:
  - 0, write: push `mem_wdata` to TX FIFO. If TX is full, the byte is dropped.
  - 0, read: pop RX FIFO and return its head. If RX is empty, return 0 and do not pop.
  - 4, write: set `halt`. `halt` clears only on reset.
  - All other I/O offsets: reads return 0, writes are ignored.
- TX FIFO:
  - `tx_valid = !empty`; `tx_data` = head (combinational from storage).
  - Pop when `tx_valid && tx_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop on empty is a no-op.
- RX FIFO:
  - `rx_ready = !full`; push when `rx_valid && rx_ready`.
  - Simultaneous push and CPU pop keep the count unchanged. When the FIFO is empty, a simultaneous push and read return 0 and the pushed byte stays.
- `io_full`: registered, high when TX count ≥ depth−2. One further write can be in flight while the controller observes the flag.
- Pointers are `FIFO_LOG` bits with natural wrap. A count of `FIFO_LOG+1` bits distinguishes full from empty.

## Timing
- Request sampled on rising edge N. Read data valid on `mem_rdata` from N+1 until the next edge, which is the one-cycle latency the controller expects. Back-to-back reads at consecutive addresses stream one byte per cycle.
- A write at edge N is visible to a read issued at edge N+1.
- A TX push at edge N makes `tx_valid` high after edge N.
- `io_full` is updated at the same edge as the count change.
- The idle controller presents read address 0. This is harmless: RAM byte 0 is read and no side effects occur.
- Reset values: `mem_rdata`=0, `tx_valid`=0 (both FIFOs emptied), `rx_ready`=1, `io_full`=0, `halt`=0. RAM contents are not cleared.
- Reset asserted mid-stream: FIFOs are emptied in that cycle. The request presented in that cycle is discarded: no write commits and no pop occurs.

## Configuration
- `MEM_RESP_RX_EN` defined: RX FIFO is present and works as described.
- `MEM_RESP_RX_EN` undefined:
  - RX FIFO is removed and `rx_ready` is tied 0.
  - A read of I/O offset 0 returns 0 with no side effect.
  - `rx_valid`/`rx_data` are ignored.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 on the next cycle → `mem_rdata`=0xA5 one cycle after the read edge. Repeat for 4 consecutive bytes streamed back-to-back.
- Write 0x41 to 0x30000 with `tx_ready`=0 → next cycle `tx_valid`=1, `tx_data`=0x41. Raise `tx_ready` for one cycle → `tx_valid`=0.
- Write 6 bytes to 0x30000 with `tx_ready`=0 → `io_full`=1 after the 6th. Two more writes fill the FIFO, and a 9th write is dropped. Drain → exactly 8 bytes emerge, in order.
- Read 0x30000 with RX empty → 0. Push 0x37 via `rx_valid`, then read 0x30000 → 0x37; a second read → 0 (with `MEM_RESP_RX_EN`).
- Write any byte to 0x30004 → `halt`=1 next cycle and held through further traffic. Assert `rst` → `halt`=0.
- Fill TX with 3 bytes, assert `rst` for 1 cycle together with a RAM write to 0x00020 → `tx_valid`=0 and a subsequent read of 0x00020 returns its prior value.

Source files
------------

// File: rtl/mem_responder_if.sv
// Byte-serial memory port between the CPU memory controller and the memory responder.
//   mem_addr  : byte address (controller -> responder)
//   mem_rw    : 1 = write, 0 = read
//   mem_wdata : write byte
//   mem_rdata : registered read byte (responder -> controller)
//   io_full   : TX FIFO near-full back-pressure flag (responder -> controller)
interface mem_responder_if;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_full;

  modport master (
    output mem_addr,
    output mem_rw,
    output mem_wdata,
    input  mem_rdata,
    input  io_full
  );

  modport slave (
    input  mem_addr,
    input  mem_rw,
    input  mem_wdata,
    output mem_rdata,
    output io_full
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: RAM array plus a memory-mapped I/O window with console TX/RX FIFOs
// and a sticky halt flag. Reads have one cycle of registered latency; writes commit at the
// issuing edge.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : memory port (slave side), see mem_responder_if
//   tx_valid_o   : TX FIFO non-empty
//   tx_data_o    : TX FIFO head byte
//   tx_ready_i   : sink accepts the head byte this cycle
//   rx_valid_i   : source offers an input byte
//   rx_data_i    : input byte
//   rx_ready_o   : RX FIFO has room
//   halt_o       : sticky stop request
//
// Build option: define MEM_RESP_RX_EN to include the RX FIFO. Without it rx_ready_o is 0,
// reads of I/O offset 0 return 0 and rx_valid_i/rx_data_i are ignored.
module mem_responder #(
  parameter int unsigned ADDR_WID = 17,
  parameter int unsigned FIFO_LOG = 3
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  output logic           tx_valid_o,
  output logic [7:0]     tx_data_o,
  input  logic           tx_ready_i,
  input  logic           rx_valid_i,
  input  logic [7:0]     rx_data_i,
  output logic           rx_ready_o,
  output logic           halt_o
);

  localparam int unsigned Depth = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] CntFull     = (FIFO_LOG+1)'(Depth);
  localparam logic [FIFO_LOG:0] CntNearFull = (FIFO_LOG+1)'(Depth - 2);

  // Address decode
  logic                io_sel;
  logic [ADDR_WID-1:0] ram_idx;
  logic                io_wr0, io_rd0, io_wr4;
  logic                ram_we;
  logic                unused_addr;

  assign io_sel  = (bus.mem_addr[17:16] == 2'b11);
  assign ram_idx = bus.mem_addr[ADDR_WID-1:0];
  assign io_wr0  = io_sel && bus.mem_rw  && (bus.mem_addr[2:0] == 3'd0);
  assign io_rd0  = io_sel && !bus.mem_rw && (bus.mem_addr[2:0] == 3'd0);
  assign io_wr4  = io_sel && bus.mem_rw  && (bus.mem_addr[2:0] == 3'd4);
  // A request presented during reset is discarded.
  assign ram_we  = !rst && !io_sel && bus.mem_rw;
  // Upper address bits are don't-care; RAM aliases across them.
  assign unused_addr = ^bus.mem_addr[31:18];

  // RAM array, never cleared
  logic [7:0] ram_q [1 << ADDR_WID];

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.mem_wdata;
  end

  // TX FIFO
  logic [7:0]          tx_mem_q [Depth];
  logic [FIFO_LOG-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [FIFO_LOG:0]   tx_cnt_q, tx_cnt_d;
  logic                tx_push, tx_pop, tx_empty, tx_full;
  logic                io_full_q, io_full_d;

  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_full    = (tx_cnt_q == CntFull);
  assign tx_push    = !rst && io_wr0 && !tx_full;
  assign tx_pop     = !tx_empty && tx_ready_i;
  assign tx_valid_o = !tx_empty;
  assign tx_data_o  = tx_mem_q[tx_rptr_q];

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + FIFO_LOG'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + FIFO_LOG'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    if (rst) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end
    // Flag tracks the new count so the controller sees it at the same edge; two slots of
    // headroom cover a write already in flight.
    io_full_d = !rst && (tx_cnt_d >= CntNearFull);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.mem_wdata;
  end

  // RX FIFO
  logic       rx_empty;
  logic [7:0] rx_head;

`ifdef MEM_RESP_RX_EN
  logic [7:0]          rx_mem_q [Depth];
  logic [FIFO_LOG-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [FIFO_LOG:0]   rx_cnt_q, rx_cnt_d;
  logic                rx_push, rx_pop;

  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_ready_o = (rx_cnt_q != CntFull);
  assign rx_head    = rx_mem_q[rx_rptr_q];
  assign rx_push    = !rst && rx_valid_i && rx_ready_o;
  // A byte pushed this cycle is not yet visible to a same-cycle read.
  assign rx_pop     = !rst && io_rd0 && !rx_empty;

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + FIFO_LOG'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + FIFO_LOG'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (rst) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_i;
    rx_wptr_q <= rx_wptr_d;
    rx_rptr_q <= rx_rptr_d;
    rx_cnt_q  <= rx_cnt_d;
  end
`else
  logic unused_rx;

  assign rx_empty   = 1'b1;
  assign rx_head    = 8'h00;
  assign rx_ready_o = 1'b0;
  assign unused_rx  = ^{rx_valid_i, rx_data_i};
`endif

  // Read data and halt
  logic [7:0] rdata_q, rdata_d;
  logic       halt_q, halt_d;

  always_comb begin
    rdata_d = 8'h00;
    if (!rst) begin
      if (io_sel) begin
        if (io_rd0 && !rx_empty) rdata_d = rx_head;
      end else if (!bus.mem_rw) begin
        rdata_d = ram_q[ram_idx];
      end
    end
    halt_d = !rst && (halt_q || io_wr4);
  end

  always_ff @(posedge clk) begin
    rdata_q   <= rdata_d;
    halt_q    <= halt_d;
    io_full_q <= io_full_d;
    tx_wptr_q <= tx_wptr_d;
    tx_rptr_q <= tx_rptr_d;
    tx_cnt_q  <= tx_cnt_d;
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.io_full   = io_full_q;
  assign halt_o        = halt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by randomized traffic,
// all checked against a queue/array reference model of the memory port.
module tb_mem_responder;

`ifdef MEM_RESP_RX_EN
  localparam bit RxEn = 1'b1;
`else
  localparam bit RxEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       halt;

  mem_responder_if bus ();

  mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx_valid_o(tx_valid),
    .tx_data_o (tx_data),
    .tx_ready_i(tx_ready),
    .rx_valid_i(rx_valid),
    .rx_data_i (rx_data),
    .rx_ready_o(rx_ready),
    .halt_o    (halt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  bit         halt_m;
  logic [7:0] rdata_m;
  bit         rdata_known;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Effect of one clock edge on the model, from the request and handshakes before the edge.
  task automatic model_edge(input bit r, input logic [31:0] a, input bit w, input logic [7:0] d,
                            input bit txr, input bit rxv, input logic [7:0] rxd);
    bit tx_full_pre, rx_room_pre, rx_has_pre, io;
    int idx;
    if (r) begin
      tx_q.delete();
      rx_q.delete();
      halt_m      = 1'b0;
      rdata_m     = 8'h00;
      rdata_known = 1'b1;
      return;
    end
    io          = (a[17:16] == 2'b11);
    idx         = int'(a[16:0]);
    tx_full_pre = (tx_q.size() == 8);
    rx_room_pre = RxEn && (rx_q.size() < 8);
    rx_has_pre  = RxEn && (rx_q.size() > 0);
    rdata_m     = 8'h00;
    rdata_known = 1'b1;
    if (tx_q.size() > 0 && txr) void'(tx_q.pop_front());
    if (io) begin
      if (w && a[2:0] == 3'd0 && !tx_full_pre) tx_q.push_back(d);
      if (w && a[2:0] == 3'd4) halt_m = 1'b1;
      if (!w && a[2:0] == 3'd0 && rx_has_pre) rdata_m = rx_q.pop_front();
    end else if (w) begin
      ram_m[idx] = d;
    end else if (ram_m.exists(idx)) begin
      rdata_m = ram_m[idx];
    end else begin
      rdata_known = 1'b0;
    end
    if (rxv && rx_room_pre) rx_q.push_back(rxd);
  endtask

  task automatic step(input bit r, input logic [31:0] a, input bit w, input logic [7:0] d,
                      input bit txr, input bit rxv, input logic [7:0] rxd);
    rst           = r;
    bus.mem_addr  = a;
    bus.mem_rw    = w;
    bus.mem_wdata = d;
    tx_ready      = txr;
    rx_valid      = rxv;
    rx_data       = rxd;
    model_edge(r, a, w, d, txr, rxv, rxd);
    @(posedge clk);
    #1;
    if (rdata_known) check("rdata", bus.mem_rdata, rdata_m);
    check("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
    check("io_full", bus.io_full, tx_q.size() >= 6);
    check("rx_ready", rx_ready, RxEn && (rx_q.size() < 8));
    check("halt", halt, halt_m);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    step(1'b0, a, 1'b1, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, a, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] got [$];
    logic [31:0] a;
    int r;

    rst           = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_rw    = 1'b0;
    bus.mem_wdata = '0;
    tx_ready      = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = '0;

    // Reset state
    step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("rst_rdata", bus.mem_rdata, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, RxEn);
    check("rst_io_full", bus.io_full, 1'b0);
    check("rst_halt", halt, 1'b0);

    // Idle controller reads byte 0; give it a known value
    wr(32'h0, 8'h00);

    // RAM write then read, then a streamed run
    wr(32'h10, 8'hA5);
    rd(32'h10);
    check("ram_a5", bus.mem_rdata, 8'hA5);
    for (int i = 0; i < 4; i++) wr(32'h40 + i, 8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      rd(32'h40 + i);
      check("ram_stream", bus.mem_rdata, 8'hC0 + 8'(i));
    end
    // Upper address bits alias
    wr(32'hFFF4_0050, 8'h3C);
    rd(32'h50);
    check("ram_wrap", bus.mem_rdata, 8'h3C);

    // Single TX byte
    wr(32'h30000, 8'h41);
    check("tx_one_valid", tx_valid, 1'b1);
    check("tx_one_data", tx_data, 8'h41);
    step(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("tx_one_drained", tx_valid, 1'b0);

    // Fill TX past full, then drain
    for (int i = 0; i < 9; i++) begin
      wr(32'h30000, 8'hB0 + 8'(i));
      if (i == 4) check("io_full_5", bus.io_full, 1'b0);
      if (i == 5) check("io_full_6", bus.io_full, 1'b1);
    end
    for (int k = 0; k < 12; k++) begin
      if (tx_valid) got.push_back(tx_data);
      step(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    end
    check("drain_cnt", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check("drain_byte", got[i], 8'hB0 + 8'(i));

    // RX path
    rd(32'h30000);
    check("rx_empty_rd", bus.mem_rdata, 8'h00);
    step(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h37);
    rd(32'h30000);
    check("rx_byte", bus.mem_rdata, RxEn ? 8'h37 : 8'h00);
    rd(32'h30000);
    check("rx_second", bus.mem_rdata, 8'h00);

    // Halt is sticky until reset
    wr(32'h30004, 8'h99);
    check("halt_set", halt, 1'b1);
    wr(32'h10, 8'h01);
    rd(32'h30000);
    wr(32'h30000, 8'h55);
    check("halt_held", halt, 1'b1);
    step(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("halt_rst", halt, 1'b0);

    // Reset mid-stream discards the concurrent write
    wr(32'h20, 8'h5A);
    for (int i = 0; i < 3; i++) wr(32'h30000, 8'h60 + 8'(i));
    step(1'b1, 32'h20, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    check("rst_mid_tx", tx_valid, 1'b0);
    rd(32'h20);
    check("rst_mid_ram", bus.mem_rdata, 8'h5A);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        a[17:16] = 2'b11;
        r = $urandom_range(0, 19);
        if (r < 14) a[2:0] = 3'd0;
        else if (r == 14) a[2:0] = 3'd4;
        else a[2:0] = 3'($urandom_range(1, 7));
      end else begin
        a[15:6] = '0;
        if (a[17:16] == 2'b11) a[17] = 1'b0;
      end
      step($urandom_range(0, 299) == 0, a, 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
